agc_gain_ctrl: RTL
==================

// Module: agc_gain_ctrl
// PURPOSE
//  Closed-loop AGC back end: consumes the averaged-power stream (pow_in/pow_valid) produced upstream from
//  the same parallel sample bus, steps a fixed-point gain toward a target power and applies that gain to
//  every parallel lane. Sits after the power averager; its output drives the ADC-side datapath downstream.
// PARAMETERS
//  DIN_WIDTH   8    signed bits per lane (in and out)
//  PARALLEL    8    lanes per word
//  POW_WIDTH   16   unsigned width of pow_in/ref_pow/hyst (= 2*DIN_WIDTH)
//  GAIN_WIDTH  16   unsigned gain width
//  GAIN_POINT  8    gain fractional bits; unity = 1<<GAIN_POINT
//  GAIN_MIN    16   lower gain clamp (raw)
//  GAIN_MAX    4095 upper gain clamp (raw)
//  SETTLE_CNT  4    pow_valid pulses ignored after each gain change (averager lag), >=1
// PORTS
//  clk        in   1                    clock
//  rst_n      in   1                    asynchronous reset, active low
//  din        in   DIN_WIDTH*PARALLEL   signed lanes, lane0 in LSBs
//  din_valid  in   1                    din qualifier
//  pow_in     in   POW_WIDTH            averaged power, unsigned
//  pow_valid  in   1                    pow_in qualifier
//  ref_pow    in   POW_WIDTH            target power, quasi-static
//  hyst       in   POW_WIDTH            dead-band half width, quasi-static
//  gain_step  in   GAIN_WIDTH           additive step per update
//  dout       out  DIN_WIDTH*PARALLEL   scaled, saturated lanes
//  dout_valid out  1                    dout qualifier
//  gain       out  GAIN_WIDTH           current gain register
//  sat        out  1                    any lane of current dout clipped
// BEHAVIOUR
//  Reset (async assert, sync release): gain=clamp(1<<GAIN_POINT), dout=0, dout_valid=0, sat=0, state TRACK, settle counter 0.
//  Datapath: 2-stage pipe, din_valid -> dout_valid latency 2, fully pipelined (1 word/cycle, no backpressure).
//   St1: prod_i = din_i(signed) * {1'b0,gain}; gain used is the registered value in that cycle.
//   St2: q_i = prod_i >>> GAIN_POINT (truncate toward -inf); clamp to [-2^(DIN_WIDTH-1), 2^(DIN_WIDTH-1)-1].
//   sat = OR of per-lane clamps, aligned with dout_valid; dout holds last value when dout_valid=0.
//  Thresholds: lo = ref_pow-hyst (floor 0), hi = ref_pow+hyst (ceil 2^POW_WIDTH-1), computed unsigned w/o wrap.
//  FSM, advances only on pow_valid:
//   TRACK : pow_in<lo -> gain=min(gain+gain_step,GAIN_MAX); pow_in>hi -> gain=max(gain-gain_step,GAIN_MIN);
//           lo<=pow_in<=hi -> no change. If gain register value actually changed -> SETTLE, cnt=SETTLE_CNT.
//   SETTLE: each pow_valid decrements cnt, no gain change; cnt reaching 0 -> TRACK (next pow_valid evaluated).
//  gain updates the cycle after pow_valid; a din_valid in that same pow_valid cycle uses the old gain.
//  Clamp hit with no value change (already at limit) stays in TRACK. Add/sub done with 1 guard bit, no wrap.
//  pow_valid and din_valid independent; simultaneous assertion needs no arbitration.
//  rst_n low mid-SETTLE or mid-pipe: all state to reset values immediately; in-flight words discarded.
// CONFIGURATION
//  AGC_FREEZE_EN defined: adds input port freeze (1b). freeze=1 -> FSM and gain hold (pow_valid ignored,
//   settle cnt held); datapath keeps running with held gain. Released -> resumes in held state.
//  Undefined: no freeze port; loop always active.
// TESTING
//  1 reset, all lanes 100, din_valid 1 cycle -> dout lanes 100, dout_valid 2 cycles later, gain=256, sat=0.
//  2 gain driven to 512, lanes {100,-100,10} -> {127,-128,20}, sat=1; lanes {-3} at gain 128 -> -2 (floor).
//  3 ref=1000,hyst=100,step=16, pow=800 -> gain 272 next cycle, SETTLE; next 4 pow=800 ignored; 5th -> 288.
//  4 pow=1100 and pow=900 -> no change; pow=1101 -> gain 256-16=240; ref=50,hyst=100,pow=0 -> no change.
//  5 gain=GAIN_MAX-4, step 16, pow low -> 4095, SETTLE; after settle pow low -> stays 4095, remains TRACK.
//  6 rst_n low during SETTLE with words in pipe -> dout=0, dout_valid=0, gain=256, TRACK; freeze=1 blocks updates.

Source files
------------

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC back end: steps a fixed-point gain toward a target power and scales all lanes.
// Optional AGC_FREEZE_EN adds a freeze input that holds the gain loop while the datapath runs.
module agc_gain_ctrl #(
  parameter int unsigned DIN_WIDTH  = 8,
  parameter int unsigned PARALLEL   = 8,
  parameter int unsigned POW_WIDTH  = 16,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned GAIN_POINT = 8,
  parameter int unsigned GAIN_MIN   = 16,
  parameter int unsigned GAIN_MAX   = 4095,
  parameter int unsigned SETTLE_CNT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DIN_WIDTH*PARALLEL-1:0]   din,
  input  logic                            din_valid,
  input  logic [POW_WIDTH-1:0]            pow_in,
  input  logic                            pow_valid,
  input  logic [POW_WIDTH-1:0]            ref_pow,
  input  logic [POW_WIDTH-1:0]            hyst,
  input  logic [GAIN_WIDTH-1:0]           gain_step,
`ifdef AGC_FREEZE_EN
  input  logic                            freeze,
`endif
  output logic [DIN_WIDTH*PARALLEL-1:0]   dout,
  output logic                            dout_valid,
  output logic [GAIN_WIDTH-1:0]           gain,
  output logic                            sat
);

  localparam int unsigned PW       = DIN_WIDTH + GAIN_WIDTH + 1;
  localparam int unsigned CntW     = $clog2(SETTLE_CNT + 1);
  localparam int unsigned UnityRaw = 1 << GAIN_POINT;
  localparam int unsigned ResetRaw = (UnityRaw < GAIN_MIN) ? GAIN_MIN :
                                     (UnityRaw > GAIN_MAX) ? GAIN_MAX : UnityRaw;
  localparam logic [GAIN_WIDTH-1:0] GainReset = GAIN_WIDTH'(ResetRaw);
  localparam logic [GAIN_WIDTH-1:0] GainMax   = GAIN_WIDTH'(GAIN_MAX);
  localparam logic [GAIN_WIDTH-1:0] GainMin   = GAIN_WIDTH'(GAIN_MIN);
  localparam logic [GAIN_WIDTH:0]   GainMaxX  = (GAIN_WIDTH + 1)'(GAIN_MAX);
  localparam logic [GAIN_WIDTH:0]   GainMinX  = (GAIN_WIDTH + 1)'(GAIN_MIN);
  localparam logic signed [PW-1:0]  OutMax    = PW'((1 << (DIN_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0]  OutMin    = -OutMax - PW'(1);

  typedef enum logic [0:0] {StTrack, StSettle} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic [GAIN_WIDTH-1:0]   gain_q;

  logic signed [PW-1:0]    prod_d [PARALLEL];
  logic signed [PW-1:0]    prod_q [PARALLEL];
  logic                    valid1_q;
  logic [DIN_WIDTH*PARALLEL-1:0] dout_d, dout_q;
  logic                    sat_d, sat_q, dout_valid_q;

  // Stage 1: widen both operands to PW so the signed product cannot overflow.
  always_comb begin
    for (int i = 0; i < PARALLEL; i++) begin
      logic signed [PW-1:0] a, b;
      a = PW'($signed(din[i*DIN_WIDTH +: DIN_WIDTH]));
      b = $signed(PW'({1'b0, gain_q}));
      prod_d[i] = a * b;
    end
  end

  always_comb begin
    dout_d = '0;
    sat_d  = 1'b0;
    for (int i = 0; i < PARALLEL; i++) begin
      logic signed [PW-1:0] q;
      q = prod_q[i] >>> GAIN_POINT;
      if (q > OutMax) begin
        dout_d[i*DIN_WIDTH +: DIN_WIDTH] = OutMax[DIN_WIDTH-1:0];
        sat_d = 1'b1;
      end else if (q < OutMin) begin
        dout_d[i*DIN_WIDTH +: DIN_WIDTH] = OutMin[DIN_WIDTH-1:0];
        sat_d = 1'b1;
      end else begin
        dout_d[i*DIN_WIDTH +: DIN_WIDTH] = q[DIN_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PARALLEL; i++) prod_q[i] <= '0;
      valid1_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      valid1_q     <= din_valid;
      dout_valid_q <= valid1_q;
      if (din_valid) begin
        for (int i = 0; i < PARALLEL; i++) prod_q[i] <= prod_d[i];
      end
      if (valid1_q) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  // Thresholds and candidate gains, all with one guard bit so nothing wraps.
  logic [POW_WIDTH-1:0]  lo, hi;
  logic [POW_WIDTH:0]    hi_sum;
  logic [GAIN_WIDTH:0]   up_sum, dn_diff;
  logic [GAIN_WIDTH-1:0] gain_up, gain_dn, gain_next;
  logic                  upd;

  always_comb begin
    lo        = (ref_pow > hyst) ? ref_pow - hyst : '0;
    hi_sum    = {1'b0, ref_pow} + {1'b0, hyst};
    hi        = hi_sum[POW_WIDTH] ? '1 : hi_sum[POW_WIDTH-1:0];
    up_sum    = {1'b0, gain_q} + {1'b0, gain_step};
    dn_diff   = {1'b0, gain_q} - {1'b0, gain_step};
    gain_up   = (up_sum > GainMaxX) ? GainMax : up_sum[GAIN_WIDTH-1:0];
    gain_dn   = (dn_diff[GAIN_WIDTH] || dn_diff < GainMinX) ? GainMin : dn_diff[GAIN_WIDTH-1:0];
    gain_next = (pow_in < lo) ? gain_up : (pow_in > hi) ? gain_dn : gain_q;
`ifdef AGC_FREEZE_EN
    upd       = pow_valid && !freeze;
`else
    upd       = pow_valid;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StTrack;
      cnt_q   <= '0;
      gain_q  <= GainReset;
    end else if (upd) begin
      unique case (state_q)
        StTrack: begin
          if (gain_next != gain_q) begin
            gain_q  <= gain_next;
            state_q <= StSettle;
            cnt_q   <= CntW'(SETTLE_CNT);
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_q <= StTrack;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign gain       = gain_q;
  assign sat        = sat_q;

endmodule
